// File: rtl/amp_noise_meas_ctrl_if.sv
// Amplifier-side bus for the noise measurement sequencer.
// master = sequencer, slave = amplifier model.
interface amp_noise_meas_ctrl_if;
  real  amp_in;
  logic amp_rst_n;
  real  amp_out_noisy;
  real  amp_out_ideal;

  modport master (
    output amp_in,
    output amp_rst_n,
    input  amp_out_noisy,
    input  amp_out_ideal
  );

  modport slave (
    input  amp_in,
    input  amp_rst_n,
    output amp_out_noisy,
    output amp_out_ideal
  );
endinterface

// File: rtl/amp_noise_meas_ctrl.sv
// Amplifier noise measurement sequencer (simulation only, real ports).
// Define AMP_MEAS_RMS_EN to accumulate sum of squares and report rms_err.
module amp_noise_meas_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16,
  parameter real         ERR_LIMIT     = 0.75
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  real                  dc_level,
  input  logic [CNT_W-1:0]     num_samples,
  amp_noise_meas_ctrl_if.master amp,
  output logic                 busy,
  output logic                 done,
  output real                  mean_err,
  output real                  max_abs_err,
  output logic [CNT_W-1:0]     viol_cnt,
  output real                  rms_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_AMP,
    S_SETTLE,
    S_ACQ,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] viol_acc;
  real              sum;
  real              max_acc;
  real              err;
  real              abs_err;

  assign err     = amp.amp_out_noisy - amp.amp_out_ideal;
  assign abs_err = (err < 0.0) ? -err : err;

`ifdef AMP_MEAS_RMS_EN
  real sum_sq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_sq  <= 0.0;
      rms_err <= 0.0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE) && start && !abort:
          sum_sq <= 0.0;
        (state == S_ACQ) && !abort:
          sum_sq <= sum_sq + err * err;
        (state == S_CALC) && !abort:
          rms_err <= $sqrt(sum_sq / real'(n_lat));
        default: ;
      endcase
    end
  end
`else
  assign rms_err = 0.0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      n_lat         <= ONE;
      cnt           <= '0;
      viol_acc      <= '0;
      sum           <= 0.0;
      max_acc       <= 0.0;
      amp.amp_in    <= 0.0;
      amp.amp_rst_n <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mean_err      <= 0.0;
      max_abs_err   <= 0.0;
      viol_cnt      <= '0;
    end else begin
      done <= 1'b0;
      // abort beats every state transition, including start in IDLE
      if (abort && state != S_IDLE) begin
        state         <= S_IDLE;
        amp.amp_in    <= 0.0;
        amp.amp_rst_n <= 1'b0;
        busy          <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state      <= S_RST_AMP;
              n_lat      <= (num_samples == '0) ? ONE : num_samples;
              cnt        <= '0;
              viol_acc   <= '0;
              sum        <= 0.0;
              max_acc    <= 0.0;
              amp.amp_in <= dc_level;
              busy       <= 1'b1;
            end
          end
          S_RST_AMP: begin
            if (cnt == ONE) begin
              state         <= S_SETTLE;
              cnt           <= '0;
              amp.amp_rst_n <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          S_SETTLE: begin
            if (cnt == SET_LAST) begin
              state <= S_ACQ;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          S_ACQ: begin
            sum <= sum + err;
            if (abs_err > max_acc) max_acc <= abs_err;
            if (abs_err > ERR_LIMIT && viol_acc != '1)
              viol_acc <= viol_acc + ONE;
            if (cnt == n_lat - ONE) begin
              state <= S_CALC;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          S_CALC: begin
            state       <= S_DONE;
            done        <= 1'b1;
            mean_err    <= sum / real'(n_lat);
            max_abs_err <= max_acc;
            viol_cnt    <= viol_acc;
          end
          S_DONE: begin
            state         <= S_IDLE;
            amp.amp_in    <= 0.0;
            amp.amp_rst_n <= 1'b0;
            busy          <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amp_noise_meas_ctrl.sv
// Directed bench for amp_noise_meas_ctrl.
// Expected results are hand-computed per scenario.
module tb_amp_noise_meas_ctrl;

  localparam int CNT_W = 16;
  localparam real TOL = 1e-9;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  real              dc_level;
  logic [CNT_W-1:0] num_samples;
  logic             busy;
  logic             done;
  real              mean_err;
  real              max_abs_err;
  logic [CNT_W-1:0] viol_cnt;
  real              rms_err;

  int n_cmp;
  int n_fail;

  amp_noise_meas_ctrl_if amp_bus ();

  amp_noise_meas_ctrl #(
    .SETTLE_CYCLES (4),
    .CNT_W         (CNT_W),
    .ERR_LIMIT     (0.75)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .dc_level    (dc_level),
    .num_samples (num_samples),
    .amp         (amp_bus),
    .busy        (busy),
    .done        (done),
    .mean_err    (mean_err),
    .max_abs_err (max_abs_err),
    .viol_cnt    (viol_cnt),
    .rms_err     (rms_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic real absr(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic set_err(input real e);
    amp_bus.amp_out_ideal = 5.0;
    amp_bus.amp_out_noisy = 5.0 + e;
  endtask

  // Leaves time at #1 after the accepting edge (edge 0).
  task automatic do_start(input real dc, input int n);
    @(negedge clk);
    start       = 1'b1;
    dc_level    = dc;
    num_samples = CNT_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int first,
                           output int pulses, output bit busy_ok);
    first   = -1;
    pulses  = 0;
    busy_ok = 1'b1;
    for (int e = 1; e <= budget; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (first < 0) first = e;
      end
      if (first < 0 && !busy) busy_ok = 1'b0;
      if (first >= 0 && e >= first + 3) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        amp_bus.amp_rst_n !== 1'b0 || viol_cnt !== '0 ||
        amp_bus.amp_in != 0.0 || mean_err != 0.0 ||
        max_abs_err != 0.0 || rms_err != 0.0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b rst_n=%b viol=%0d (req 0s)",
               busy, done, amp_bus.amp_rst_n, viol_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_normal();
    int first, pulses;
    bit bok;
    real exp_rms;
`ifdef AMP_MEAS_RMS_EN
    exp_rms = 0.1;
`else
    exp_rms = 0.0;
`endif
    set_err(0.1);
    do_start(0.5, 8);
    n_cmp++;
    if (amp_bus.amp_in != 0.5 || amp_bus.amp_rst_n !== 1'b0 ||
        busy !== 1'b1) begin
      n_fail++;
      $display("FAIL normal_rst_amp: amp_in=%f rst_n=%b busy=%b req 0.5/0/1",
               amp_bus.amp_in, amp_bus.amp_rst_n, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (amp_bus.amp_rst_n !== 1'b1 || amp_bus.amp_in != 0.5) begin
      n_fail++;
      $display("FAIL normal_settle: rst_n=%b amp_in=%f req 1/0.5",
               amp_bus.amp_rst_n, amp_bus.amp_in);
    end
    wait_done(30, first, pulses, bok);
    n_cmp++;
    if (first + 2 != 15 || pulses != 1 || !bok) begin
      n_fail++;
      $display("FAIL normal_timing: done edge=%0d pulses=%0d busy_ok=%0d req 15/1/1",
               first + 2, pulses, bok);
    end
    n_cmp++;
    if (absr(mean_err - 0.1) > TOL || absr(max_abs_err - 0.1) > TOL ||
        viol_cnt !== 16'd0 || absr(rms_err - exp_rms) > TOL) begin
      n_fail++;
      $display("FAIL normal_results: mean=%f max=%f viol=%0d rms=%f req 0.1/0.1/0/%f",
               mean_err, max_abs_err, viol_cnt, rms_err, exp_rms);
    end
    n_cmp++;
    if (busy !== 1'b0 || amp_bus.amp_rst_n !== 1'b0 ||
        amp_bus.amp_in != 0.0) begin
      n_fail++;
      $display("FAIL normal_idle: busy=%b rst_n=%b amp_in=%f req 0/0/0.0",
               busy, amp_bus.amp_rst_n, amp_bus.amp_in);
    end
  endtask

  task automatic test_violations();
    real errs [4];
    int first, pulses;
    bit bok;
    real exp_rms;
    errs[0] = 0.8;
    errs[1] = -0.9;
    errs[2] = 0.75;
    errs[3] = 0.2;
`ifdef AMP_MEAS_RMS_EN
    exp_rms = $sqrt(2.0525 / 4.0);
`else
    exp_rms = 0.0;
`endif
    set_err(0.0);
    do_start(1.0, 4);
    repeat (6) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      amp_bus.amp_out_ideal = 0.0;
      amp_bus.amp_out_noisy = errs[i];
      @(posedge clk);
    end
    #1;
    wait_done(20, first, pulses, bok);
    n_cmp++;
    if (first + 10 != 11 || pulses != 1) begin
      n_fail++;
      $display("FAIL viol_timing: done edge=%0d pulses=%0d req 11/1",
               first + 10, pulses);
    end
    n_cmp++;
    if (viol_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL viol_cnt: got %0d req 2", viol_cnt);
    end
    n_cmp++;
    if (absr(max_abs_err - 0.9) > TOL || absr(mean_err - 0.2125) > TOL ||
        absr(rms_err - exp_rms) > TOL) begin
      n_fail++;
      $display("FAIL viol_stats: max=%f mean=%f rms=%f req 0.9/0.2125/%f",
               max_abs_err, mean_err, rms_err, exp_rms);
    end
  endtask

  task automatic test_zero_samples();
    int first, pulses;
    bit bok;
    set_err(0.3);
    do_start(0.2, 0);
    wait_done(30, first, pulses, bok);
    n_cmp++;
    if (first != 8 || pulses != 1 || !bok) begin
      n_fail++;
      $display("FAIL zero_n_timing: done edge=%0d pulses=%0d busy_ok=%0d req 8/1/1",
               first, pulses, bok);
    end
    n_cmp++;
    if (absr(mean_err - 0.3) > 1e-6 || absr(max_abs_err - 0.3) > 1e-6 ||
        viol_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL zero_n_results: mean=%f max=%f viol=%0d req 0.3/0.3/0",
               mean_err, max_abs_err, viol_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int first, pulses;
    bit bok;
    set_err(0.1);
    do_start(0.5, 8);
    repeat (8) @(posedge clk);
    #1;
    start       = 1'b1;
    num_samples = CNT_W'(2);
    dc_level    = 2.0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (amp_bus.amp_in != 0.5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_drive: amp_in=%f busy=%b req 0.5/1",
               amp_bus.amp_in, busy);
    end
    wait_done(30, first, pulses, bok);
    n_cmp++;
    if (first + 9 != 15 || pulses != 1 || !bok) begin
      n_fail++;
      $display("FAIL busy_start_timing: done edge=%0d pulses=%0d busy_ok=%0d req 15/1/1",
               first + 9, pulses, bok);
    end
    n_cmp++;
    if (absr(mean_err - 0.1) > TOL || viol_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL busy_start_results: mean=%f viol=%0d req 0.1/0",
               mean_err, viol_cnt);
    end
  endtask

  task automatic test_abort();
    int seen;
    set_err(0.6);
    do_start(0.7, 8);
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || amp_bus.amp_rst_n !== 1'b0 ||
        amp_bus.amp_in != 0.0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b rst_n=%b amp_in=%f req 0/0/0.0",
               busy, amp_bus.amp_rst_n, amp_bus.amp_in);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    n_cmp++;
    if (seen != 0 || absr(mean_err - 0.1) > TOL ||
        absr(max_abs_err - 0.1) > TOL) begin
      n_fail++;
      $display("FAIL abort_hold: done_pulses=%0d mean=%f max=%f req 0/0.1/0.1",
               seen, mean_err, max_abs_err);
    end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || amp_bus.amp_in != 0.0) begin
      n_fail++;
      $display("FAIL abort_start_same: busy=%b amp_in=%f req 0/0.0",
               busy, amp_bus.amp_in);
    end
  endtask

  task automatic test_async_reset();
    int first, pulses;
    bit bok;
    set_err(0.4);
    do_start(0.9, 3);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || amp_bus.amp_rst_n !== 1'b0 ||
        amp_bus.amp_in != 0.0 || mean_err != 0.0 ||
        max_abs_err != 0.0 || viol_cnt !== '0 || rms_err != 0.0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b rst_n=%b amp_in=%f mean=%f req 0/0/0.0/0.0",
               busy, amp_bus.amp_rst_n, amp_bus.amp_in, mean_err);
    end
    @(negedge clk);
    rst = 1'b0;
    set_err(-0.2);
    do_start(0.5, 8);
    wait_done(30, first, pulses, bok);
    n_cmp++;
    if (first != 15 || pulses != 1 || absr(mean_err + 0.2) > 1e-6 ||
        absr(max_abs_err - 0.2) > 1e-6) begin
      n_fail++;
      $display("FAIL post_reset_run: edge=%0d pulses=%0d mean=%f max=%f req 15/1/-0.2/0.2",
               first, pulses, mean_err, max_abs_err);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    start       = 1'b0;
    abort       = 1'b0;
    dc_level    = 0.0;
    num_samples = '0;
    set_err(0.0);
    test_reset();
    test_normal();
    test_violations();
    test_zero_samples();
    test_normal();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
